// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU operation codes, instruction field positions and
// the decoded bundle handed from decode to the ALU.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  // ALU operation codes (shared with the ALU).
  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_SLL    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_SLT    = 5'd8;
  localparam logic [4:0] OP_EQ     = 5'd9;
  localparam logic [4:0] OP_NEQ    = 5'd10;
  localparam logic [4:0] OP_ADDI   = 5'd11;
  localparam logic [4:0] OP_ANDI   = 5'd12;
  localparam logic [4:0] OP_ORI    = 5'd13;
  localparam logic [4:0] OP_XORI   = 5'd14;
  localparam logic [4:0] OP_SLLI   = 5'd15;
  localparam logic [4:0] OP_SRLI   = 5'd16;
  localparam logic [4:0] OP_SRAI   = 5'd17;
  localparam logic [4:0] OP_SLTI   = 5'd18;
  localparam logic [4:0] OP_EQI    = 5'd19;
  localparam logic [4:0] OP_NEQI   = 5'd20;
  localparam logic [4:0] OP_LW     = 5'd21;
  localparam logic [4:0] OP_SW     = 5'd22;
  localparam logic [4:0] OP_BT     = 5'd23;
  localparam logic [4:0] OP_BF     = 5'd24;
  localparam logic [4:0] OP_JAL    = 5'd25;
  localparam logic [4:0] OP_JALR   = 5'd26;
  localparam logic [4:0] OP_LI     = 5'd27;
  localparam logic [4:0] OP_LUI    = 5'd28;
  localparam logic [4:0] OP_AUITPC = 5'd29;
  localparam logic [4:0] OP_ECALL  = 5'd30;
  localparam logic [4:0] OP_EBREAK = 5'd31;

  // Instruction field bit positions.
  localparam int unsigned OP_MSB    = 31;
  localparam int unsigned OP_LSB    = 27;
  localparam int unsigned RD_MSB    = 26;
  localparam int unsigned RD_LSB    = 22;
  localparam int unsigned RS1_MSB   = 21;
  localparam int unsigned RS1_LSB   = 17;
  localparam int unsigned RS2_MSB   = 16;
  localparam int unsigned RS2_LSB   = 12;
  localparam int unsigned IMM17_MSB = 16;
  localparam int unsigned IMM22_MSB = 21;

  typedef struct packed {
    logic use_imm;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic trap;
  } flags_t;

  typedef struct packed {
    logic [4:0]      alu_op;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    flags_t          flags;
  } decoded_t;

  function automatic logic [XLEN-1:0] sext17(input logic [IMM17_MSB:0] v);
    return {{(XLEN-IMM17_MSB-1){v[IMM17_MSB]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] sext22(input logic [IMM22_MSB:0] v);
    return {{(XLEN-IMM22_MSB-1){v[IMM22_MSB]}}, v};
  endfunction

endpackage

// File: rtl/decode_stage_skid_buffer.sv
// Two-entry skid buffer with registered in_ready and a flush that empties it.
module skid_buffer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t       r_state;
  state_t       w_next;
  logic         r_in_ready;
  logic [W-1:0] r_main;
  logic [W-1:0] r_skid;
  logic         w_accept;
  logic         w_drain;
  logic         w_load_main;
  logic         w_load_skid;
  logic         w_shift;

  assign w_accept = in_valid & r_in_ready;
  assign w_drain  = out_valid & out_ready;
  assign in_ready = r_in_ready;
  assign out_data = r_main;

  // Next state, slot load controls and out_valid from the current occupancy.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    w_next      = r_state;
    w_load_main = 1'b0;
    w_load_skid = 1'b0;
    w_shift     = 1'b0;
    out_valid   = (r_state != S_EMPTY);
    if (flush) begin
      w_next = S_EMPTY;
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_next      = S_ONE;
            w_load_main = 1'b1;
          end
        end
        S_ONE: begin
          if (w_accept && w_drain) begin
            w_load_main = 1'b1;
          end else if (w_accept) begin
            w_next      = S_TWO;
            w_load_skid = 1'b1;
          end else if (w_drain) begin
            w_next = S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_drain) begin
            w_next  = S_ONE;
            w_shift = 1'b1;
          end
        end
        default: w_next = S_EMPTY;
      endcase
    end
  end

  // State, ready flop and slot storage.
  always_ff @(posedge clk) begin
    // NOTE: state updates use <= so every flop samples pre-edge values.
    if (!rst_n) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
      // NOTE: main is cleared because it drives the outputs; skid is only read after being written.
      r_main     <= '0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != S_TWO);
      if (w_load_main) r_main <= in_data;
      else if (w_shift) r_main <= r_skid;
      if (w_load_skid) r_skid <= in_data;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: decodes fetch beats into ALU bundles and buffers
// them in a two-entry skid buffer.
module decode_stage
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_alu_op,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic            out_use_imm,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_trap
);

  function automatic decoded_t decode(input logic [XLEN-1:0] instr,
                                      input logic [XLEN-1:0] pc);
    decoded_t   d;
    logic [4:0] op;
    op       = instr[OP_MSB:OP_LSB];
    d        = '0;
    d.alu_op = op;
    d.pc     = pc;
    case (op) inside
      [OP_ADD:OP_NEQ]: begin
        d.rd              = instr[RD_MSB:RD_LSB];
        d.rs1             = instr[RS1_MSB:RS1_LSB];
        d.rs2             = instr[RS2_MSB:RS2_LSB];
        d.flags.reg_write = 1'b1;
      end
      [OP_ADDI:OP_LW], OP_JALR: begin
        d.rd              = instr[RD_MSB:RD_LSB];
        d.rs1             = instr[RS1_MSB:RS1_LSB];
        d.imm             = sext17(instr[IMM17_MSB:0]);
        d.flags.use_imm   = 1'b1;
        d.flags.reg_write = 1'b1;
        d.flags.mem_read  = (op == OP_LW);
        d.flags.jump      = (op == OP_JALR);
      end
      OP_SW: begin
        d.rs2             = instr[RD_MSB:RD_LSB];
        d.rs1             = instr[RS1_MSB:RS1_LSB];
        d.imm             = sext17(instr[IMM17_MSB:0]);
        d.flags.use_imm   = 1'b1;
        d.flags.mem_write = 1'b1;
      end
      OP_BT, OP_BF: begin
        d.rs1          = instr[RD_MSB:RD_LSB];
        d.rs2          = instr[RS1_MSB:RS1_LSB];
        d.imm          = sext17(instr[IMM17_MSB:0]);
        d.flags.branch = 1'b1;
      end
      OP_JAL: begin
        d.rd              = instr[RD_MSB:RD_LSB];
        d.imm             = sext22(instr[IMM22_MSB:0]);
        d.flags.jump      = 1'b1;
        d.flags.reg_write = 1'b1;
      end
      OP_LI: begin
        d.rd              = instr[RD_MSB:RD_LSB];
        d.imm             = sext22(instr[IMM22_MSB:0]);
        d.flags.use_imm   = 1'b1;
        d.flags.reg_write = 1'b1;
      end
      OP_LUI, OP_AUITPC: begin
        d.rd              = instr[RD_MSB:RD_LSB];
        d.imm             = {instr[IMM22_MSB:0], 10'b0};
        d.flags.use_imm   = 1'b1;
        d.flags.reg_write = 1'b1;
      end
      default: begin
        d.flags.trap = 1'b1;
      end
    endcase
    // Writes to x0 are architecturally discarded.
    if (d.rd == 5'd0) d.flags.reg_write = 1'b0;
    return d;
  endfunction

  decoded_t w_dec;
  decoded_t w_out;

  assign w_dec = decode(in_instr, in_pc);

  skid_buffer #(.W($bits(decoded_t))) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out)
  );

  assign out_alu_op    = w_out.alu_op;
  assign out_rd        = w_out.rd;
  assign out_rs1       = w_out.rs1;
  assign out_rs2       = w_out.rs2;
  assign out_imm       = w_out.imm;
  assign out_pc        = w_out.pc;
  assign out_use_imm   = w_out.flags.use_imm;
  assign out_reg_write = w_out.flags.reg_write;
  assign out_mem_read  = w_out.flags.mem_read;
  assign out_mem_write = w_out.flags.mem_write;
  assign out_branch    = w_out.flags.branch;
  assign out_jump      = w_out.flags.jump;
  assign out_trap      = w_out.flags.trap;

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined instruction decode stage sitting directly upstream of the ALU: it accepts 32-bit instruction words from fetch, decodes them into the 5-bit `alu_op` code space the ALU consumes, and emits register addresses, a sign-extended immediate and control flags. A two-entry skid buffer gives full throughput with a registered `in_ready`. A flush input discards all buffered and incoming work on a taken branch or jump.

## Interface
- `XLEN`, 32: instruction and immediate width.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `flush`  in  1  discard all held and incoming instructions.
- `in_valid`  in  1  fetch presents `in_instr`.
- `in_ready`  out  1  stage can accept a beat (registered).
- `in_instr`  in  32  instruction word.
- `in_pc`  in  32  PC of `in_instr`.
- `out_valid`  out  1  decoded bundle valid.
- `out_ready`  in  1  downstream accepts bundle.
- `out_alu_op`  out  5  ALU operation code (0..31, same code space as ALU).
- `out_rd`, `out_rs1`, `out_rs2`  out  5 each  register addresses.
- `out_imm`  out  32  sign-extended immediate.
- `out_pc`  out  32  PC passed through.
- `out_use_imm`  out  1  ALU operand 2 = `out_imm` instead of rs2 data.
- `out_reg_write`, `out_mem_read`, `out_mem_write`, `out_branch`, `out_jump`, `out_trap`  out  1 each  control flags.

## Operation
- Fields: op = instr[31:27] (equals `alu_op` directly); rd = [26:22]; rs1 = [21:17]; rs2 = [16:12]; imm17 = [16:0]; imm22 = [21:0]; all immediates sign-extended to 32 bits.
- R-type (ADD..NEQ, codes 0–10): rd, rs1, rs2; use_imm=0; reg_write=1.
- I-type ALU (ADDI..NEQI, 11–20), LW (21), JALR (26): rd, rs1, imm17; use_imm=1; reg_write=1. LW sets mem_read. JALR sets jump.
- SW (22): rs2 = [26:22] (data), rs1 = [21:17] (base), imm17; use_imm=1; mem_write=1; reg_write=0.
- BT/BF (23/24): rs1 = [26:22], rs2 = [21:17], imm17 offset; use_imm=0; branch=1; reg_write=0.
- JAL (25): rd, imm22; jump=1; reg_write=1.
- LI (27): rd, imm22; LUI (28): rd, imm = {instr[21:0], 10'b0}; AUITPC (29): rd, imm = {instr[21:0], 10'b0}. All three: use_imm=1, reg_write=1.
- ECALL/EBREAK (30/31): trap=1; reg_write=0.
- Unused address fields output 0. reg_write is forced 0 when rd = 0.
- Skid buffer has three states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: main slot valid, in_ready=1.
  - TWO: main and skid slots valid, in_ready=0.
- Transitions:
  - accept without drain: EMPTY→ONE, ONE→TWO.
  - drain without accept: ONE→EMPTY, TWO→ONE (skid moves into main).
  - accept and drain together in ONE: stays ONE; the new beat replaces main.
- Decode is performed on entry to a slot; both slots hold decoded bundles.
- flush: next state EMPTY regardless of in_valid or out_ready. A beat handshaken in the flush cycle is dropped. A bundle with out_valid & out_ready in the flush cycle counts as consumed.

## Timing
- Latency 1 cycle: a beat accepted at edge N appears on outputs after edge N (out_valid high in cycle N+1).
- Throughput 1 instruction/cycle while out_ready stays high.
- in_ready is a flop output: high iff the state after the edge is not TWO, so it never depends combinationally on out_ready.
- Outputs are stable while out_valid & !out_ready.
- Reset (rst_n=0 at edge): state EMPTY, out_valid=0, in_ready=1, all data/flag outputs 0.
- Reset mid-stream drops all held bundles.
- Reset has priority over flush.

## Structure
- Shared package `cpu_pkg` holds:
  - the `alu_op` code localparams (ADD=0 … EBREAK=31), shared with the ALU;
  - the field bit-position constants;
  - a packed `decoded_t` struct (alu_op, rd, rs1, rs2, imm, pc, flags).
- Sub-module `skid_buffer` is parameterised on payload width and carries `decoded_t` with the valid/ready and flush logic.
- The combinational decode function lives in `decode_stage`.

## Test plan
- Reset, then ADDI rd=3, rs1=1, imm=-5 (0x1FFFB): out_alu_op=11, out_imm=0xFFFFFFFB, use_imm=1, reg_write=1; out_valid rises 1 cycle after the handshake.
- Stream of 8 back-to-back R-type instructions with out_ready held high: 8 bundles in order, no bubbles, in_ready constantly 1.
- out_ready low for 3 cycles while 2 instructions arrive: in_ready drops after the second beat. Release out_ready: both bundles delivered in order, and outputs stay stable while stalled.
- SW with [26:22]=7, [21:17]=2, imm17=8: out_rs2=7, out_rs1=2, out_imm=8, mem_write=1, reg_write=0. LUI imm22=0x3: out_imm=0x00000C00.
- Hold state TWO and assert flush together with in_valid: out_valid=0 and in_ready=1 next cycle, and no dropped instruction ever appears on the outputs.
- ADD with rd=0: reg_write=0. EBREAK: alu_op=31, trap=1. Assert rst_n=0 mid-stream: out_valid=0 and all outputs 0 after the edge.
